// File: rtl/emc_capture_target.sv
// EMC chip-select-0 responder: pixel FIFO read window, status, control and scratch registers.
// One pop or one register write per chip-select low period; read data is registered into EMC_DB_OUT.
module emc_capture_target #(
  parameter int ADDR_W          = 2,
  parameter int DATA_W          = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic              EMC_CS_N,
  input  logic              EMC_OEN_N,
  input  logic              EMC_RW_N,
  input  logic [ADDR_W-1:0] EMC_AB,
  input  logic [1:0]        EMC_BYTEN,
  input  logic [DATA_W-1:0] EMC_DB_IN,
  output logic [DATA_W-1:0] EMC_DB_OUT,
  output logic              EMC_DB_OE,
  input  logic [DATA_W-1:0] PIX_DATA,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  output logic              IRQ
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int PW    = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RD_DATA, HOLD} state_t;

  state_t            state, state_nx;
  logic              armed;
  logic              rd_start, wr_start;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              empty, full;
  logic              enable, overflow;
  logic [DATA_W-1:0] scratch;

  logic              push, pop, flush, clr_ovf;
  logic [DATA_W-1:0] status, ctrl_rd, rd_val;

  always_ff @(posedge SYSCLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  // armed holds off new accesses after reset until the bus has deselected once
  always_comb begin
    state_nx  = state;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    EMC_DB_OE = 1'b0;
    case (state)
      IDLE: begin
        if (!EMC_CS_N && armed) begin
          if (!EMC_RW_N) begin
            wr_start = 1'b1;
            state_nx = HOLD;
          end else if (!EMC_OEN_N) begin
            rd_start = 1'b1;
            state_nx = RD_DATA;
          end
        end
      end
      RD_DATA: begin
        EMC_DB_OE = 1'b1;
        if (EMC_CS_N) state_nx = IDLE;
      end
      HOLD: begin
        if (EMC_CS_N) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET)         armed <= 1'b0;
    else if (EMC_CS_N) armed <= 1'b1;
  end

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign PIX_READY = enable && !full;
  assign IRQ       = enable && (count >= CW'(DEPTH / 2));

  assign pop     = rd_start && (EMC_AB == ADDR_W'(0)) && !empty;
  assign flush   = wr_start && (EMC_AB == ADDR_W'(2)) && !EMC_BYTEN[0] && EMC_DB_IN[2];
  assign clr_ovf = wr_start && (EMC_AB == ADDR_W'(2)) && !EMC_BYTEN[0] && EMC_DB_IN[1];
  assign push    = PIX_VALID && PIX_READY && !flush;

  always_comb begin
    status                = '0;
    status[CW-1:0]        = count;
    status[8]             = empty;
    status[9]             = full;
    status[10]            = overflow;
    ctrl_rd               = '0;
    ctrl_rd[0]            = enable;
    rd_val                = '0;
    case (EMC_AB)
      ADDR_W'(0): rd_val = empty ? '0 : mem[rptr];
      ADDR_W'(1): rd_val = status;
      ADDR_W'(2): rd_val = ctrl_rd;
      default:    rd_val = scratch;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (push) mem[wptr] <= PIX_DATA;
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // a new overflow outranks a same-cycle clear
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      overflow <= 1'b0;
    end else if (PIX_VALID && enable && full) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      enable  <= 1'b0;
      scratch <= '0;
    end else if (wr_start) begin
      if (EMC_AB == ADDR_W'(2) && !EMC_BYTEN[0]) enable <= EMC_DB_IN[0];
      if (EMC_AB == ADDR_W'(3)) begin
        if (!EMC_BYTEN[0]) scratch[7:0]        <= EMC_DB_IN[7:0];
        if (!EMC_BYTEN[1]) scratch[DATA_W-1:8] <= EMC_DB_IN[DATA_W-1:8];
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET)         EMC_DB_OUT <= '0;
    else if (rd_start) EMC_DB_OUT <= rd_val;
  end

endmodule

// File: tb/tb_emc_capture_target.sv
// Directed bench for emc_capture_target: bus tasks queue expected read data,
// a monitor compares it each time EMC_DB_OE rises.
module tb_emc_capture_target;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic        EMC_CS_N, EMC_OEN_N, EMC_RW_N;
  logic [1:0]  EMC_AB;
  logic [1:0]  EMC_BYTEN;
  logic [15:0] EMC_DB_IN, EMC_DB_OUT;
  logic        EMC_DB_OE;
  logic [15:0] PIX_DATA;
  logic        PIX_VALID, PIX_READY, IRQ;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expq[$];
  logic        oe_prev = 1'b0;

  emc_capture_target #(.ADDR_W(2), .DATA_W(16), .FIFO_DEPTH_LOG2(4)) dut (
    .SYSCLK(SYSCLK), .RESET(RESET),
    .EMC_CS_N(EMC_CS_N), .EMC_OEN_N(EMC_OEN_N), .EMC_RW_N(EMC_RW_N),
    .EMC_AB(EMC_AB), .EMC_BYTEN(EMC_BYTEN), .EMC_DB_IN(EMC_DB_IN),
    .EMC_DB_OUT(EMC_DB_OUT), .EMC_DB_OE(EMC_DB_OE),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .IRQ(IRQ)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: every rising OE presents one read word
  always @(negedge SYSCLK) begin
    if (EMC_DB_OE === 1'b1 && !oe_prev) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got 0x%04h with no expected word", EMC_DB_OUT);
      end else begin
        chk("read_data", EMC_DB_OUT, expq.pop_front());
      end
    end
    oe_prev = (EMC_DB_OE === 1'b1);
  end

  task automatic emc_read(input logic [1:0] a, input logic [15:0] exp, input int unsigned hold);
    @(negedge SYSCLK);
    EMC_CS_N = 1'b0; EMC_RW_N = 1'b1; EMC_OEN_N = 1'b0; EMC_AB = a;
    expq.push_back(exp);
    @(negedge SYSCLK);
    chk("oe_latency", 16'(EMC_DB_OE), 16'h1);
    repeat (hold - 1) @(negedge SYSCLK);
    chk("oe_hold", 16'(EMC_DB_OE), 16'h1);
    EMC_CS_N = 1'b1; EMC_OEN_N = 1'b1;
    @(negedge SYSCLK);
    chk("oe_drop", 16'(EMC_DB_OE), 16'h0);
  endtask

  task automatic emc_write(input logic [1:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge SYSCLK);
    EMC_CS_N = 1'b0; EMC_RW_N = 1'b0; EMC_AB = a; EMC_DB_IN = d; EMC_BYTEN = be;
    @(negedge SYSCLK);
    EMC_CS_N = 1'b1; EMC_RW_N = 1'b1; EMC_BYTEN = 2'b11;
    @(negedge SYSCLK);
  endtask

  task automatic push_pix(input logic [15:0] d, input logic exp_ready);
    @(negedge SYSCLK);
    PIX_VALID = 1'b1; PIX_DATA = d;
    chk("pix_ready", 16'(PIX_READY), 16'(exp_ready));
    @(negedge SYSCLK);
    PIX_VALID = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; EMC_CS_N = 1'b1; EMC_RW_N = 1'b1; EMC_OEN_N = 1'b1;
    EMC_AB = '0; EMC_BYTEN = 2'b11; EMC_DB_IN = '0; PIX_DATA = '0; PIX_VALID = 1'b0;
    repeat (3) @(negedge SYSCLK);
    chk("rst_db_out", EMC_DB_OUT, 16'h0000);
    chk("rst_oe", 16'(EMC_DB_OE), 16'h0);
    chk("rst_pix_ready", 16'(PIX_READY), 16'h0);
    chk("rst_irq", 16'(IRQ), 16'h0);
    RESET = 1'b0;

    emc_read(2'd1, 16'h0100, 1);

    // Basic FIFO ordering
    emc_write(2'd2, 16'h0001, 2'b00);
    push_pix(16'h1234, 1'b1);
    push_pix(16'hABCD, 1'b1);
    emc_read(2'd0, 16'h1234, 1);
    emc_read(2'd0, 16'hABCD, 2);
    emc_read(2'd1, 16'h0100, 1);
    emc_read(2'd0, 16'h0000, 1);
    emc_read(2'd1, 16'h0100, 1);

    // Long select pops once
    push_pix(16'h0001, 1'b1);
    push_pix(16'h0002, 1'b1);
    push_pix(16'h0003, 1'b1);
    emc_read(2'd0, 16'h0001, 8);
    emc_read(2'd1, 16'h0002, 1);
    emc_read(2'd0, 16'h0002, 1);
    emc_read(2'd0, 16'h0003, 1);

    // Fill past full: overflow, IRQ threshold
    for (int unsigned i = 0; i < 18; i++) begin
      push_pix(16'h1000 + 16'(i), i < 16);
      if (i == 6) chk("irq_below_half", 16'(IRQ), 16'h0);
      if (i == 7) chk("irq_at_half", 16'(IRQ), 16'h1);
    end
    chk("pix_ready_full", 16'(PIX_READY), 16'h0);
    emc_read(2'd1, 16'h0610, 1);
    emc_write(2'd2, 16'h0003, 2'b00);
    emc_read(2'd1, 16'h0210, 1);
    emc_read(2'd2, 16'h0001, 1);
    emc_read(2'd0, 16'h1000, 1);
    emc_read(2'd1, 16'h000F, 1);

    // Scratch byte enables
    emc_write(2'd3, 16'h0000, 2'b00);
    emc_read(2'd3, 16'h0000, 1);
    emc_write(2'd3, 16'hBEEF, 2'b01);
    emc_read(2'd3, 16'hBE00, 1);
    emc_write(2'd3, 16'h1234, 2'b10);
    emc_read(2'd3, 16'hBE34, 1);

    // Flush coinciding with a pixel push
    @(negedge SYSCLK);
    EMC_CS_N = 1'b0; EMC_RW_N = 1'b0; EMC_AB = 2'd2; EMC_DB_IN = 16'h0005; EMC_BYTEN = 2'b00;
    PIX_VALID = 1'b1; PIX_DATA = 16'h5555;
    @(negedge SYSCLK);
    PIX_VALID = 1'b0; EMC_CS_N = 1'b1; EMC_RW_N = 1'b1; EMC_BYTEN = 2'b11;
    @(negedge SYSCLK);
    chk("irq_after_flush", 16'(IRQ), 16'h0);
    emc_read(2'd1, 16'h0100, 1);
    emc_read(2'd2, 16'h0001, 1);

    // Reset in the middle of a read
    push_pix(16'h0A0A, 1'b1);
    push_pix(16'h0B0B, 1'b1);
    @(negedge SYSCLK);
    EMC_CS_N = 1'b0; EMC_RW_N = 1'b1; EMC_OEN_N = 1'b0; EMC_AB = 2'd0;
    expq.push_back(16'h0A0A);
    @(negedge SYSCLK);
    chk("midrst_oe_before", 16'(EMC_DB_OE), 16'h1);
    RESET = 1'b1;
    @(negedge SYSCLK);
    chk("midrst_oe", 16'(EMC_DB_OE), 16'h0);
    chk("midrst_db_out", EMC_DB_OUT, 16'h0000);
    chk("midrst_pix_ready", 16'(PIX_READY), 16'h0);
    RESET = 1'b0;
    repeat (2) begin
      @(negedge SYSCLK);
      chk("no_rearm_oe", 16'(EMC_DB_OE), 16'h0);
    end
    EMC_CS_N = 1'b1; EMC_OEN_N = 1'b1;
    @(negedge SYSCLK);
    emc_read(2'd1, 16'h0100, 1);

    repeat (2) @(negedge SYSCLK);
    chk("queue_drained", 16'(expq.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
